// File: rtl/gfmux_pkg.sv
// Shared types and helpers for the glitch-free registered channel mux.
package gfmux_pkg;

    typedef enum logic [1:0] {
        GF_IDLE   = 2'd0,
        GF_HOLD   = 2'd1,
        GF_SWITCH = 2'd2
    } gf_state_t;

    // Select width for n channels; never narrower than one bit.
    function automatic int gf_selw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gfmux_hold_cnt.sv
// Loadable down-counter that times the output-freeze window of a select change.
module gfmux_hold_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            en,
    output logic            zero
);

    logic [CNTW-1:0] cnt_r;

    // Load has priority; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNTW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNTW{1'b0}});

endmodule

// File: rtl/glitch_free_mux_reg.sv
// Registered N-channel mux whose select changes by handshake behind a frozen-output window.
// Build option GFMUX_BLANK_EN: drive mux_out to zero while a switch is in progress.
module glitch_free_mux_reg
    import gfmux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int SELW     = gf_selw(NCH),
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 sel_req,
    output logic                 sel_ack,
    output logic                 sel_err,
    output logic                 busy,
    output logic [SELW-1:0]      cur_sel,
    output logic [WIDTH-1:0]     mux_out,
    output logic                 mux_valid
);

    localparam int              CNTW  = $clog2(HOLD_CYC + 1);
    localparam logic [SELW:0]   NCH_V = (SELW + 1)'(NCH);
    localparam logic [CNTW-1:0] LOADV = CNTW'(HOLD_CYC - 1);

    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("glitch_free_mux_reg: HOLD_CYC must be at least 1");
    end

    function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] d,
                                              input logic [SELW-1:0] s);
        return d[int'(s)*WIDTH +: WIDTH];
    endfunction

    gf_state_t         state_r;
    logic [SELW-1:0]   cur_sel_r;
    logic [SELW-1:0]   pending_r;
    logic [WIDTH-1:0]  mux_out_r;
    logic              mux_valid_r;
    logic              busy_r;
    logic              sel_ack_r;
    logic              sel_err_r;

    logic              req_bad_s;
    logic              req_same_s;
    logic              req_go_s;
    logic              cnt_load_s;
    logic              cnt_en_s;
    logic              cnt_zero_s;

    // Classify the incoming request and drive the hold counter controls.
    always_comb begin
        req_bad_s  = 1'b0;
        req_same_s = 1'b0;
        req_go_s   = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        if (sel_req && (state_r == GF_IDLE)) begin
            if ({1'b0, sel_in} >= NCH_V) begin
                req_bad_s = 1'b1;
            end else if (sel_in == cur_sel_r) begin
                req_same_s = 1'b1;
            end else begin
                req_go_s = 1'b1;
            end
        end else begin
            req_go_s = 1'b0;
        end
        cnt_load_s = req_go_s;
        cnt_en_s   = (state_r == GF_HOLD);
    end

    gfmux_hold_cnt #(
        .CNTW (CNTW)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (LOADV),
        .en       (cnt_en_s),
        .zero     (cnt_zero_s)
    );

    // Select-change FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= GF_IDLE;
            cur_sel_r   <= {SELW{1'b0}};
            pending_r   <= {SELW{1'b0}};
            mux_out_r   <= {WIDTH{1'b0}};
            mux_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sel_ack_r   <= 1'b0;
            sel_err_r   <= 1'b0;
        end else begin
            sel_ack_r <= 1'b0;
            sel_err_r <= 1'b0;
            case (state_r)
                GF_IDLE: begin
                    mux_out_r   <= pick(data_in, cur_sel_r);
                    mux_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    if (req_bad_s) begin
                        sel_err_r <= 1'b1;
                    end else if (req_same_s) begin
                        sel_ack_r <= 1'b1;
                    end else if (req_go_s) begin
                        pending_r   <= sel_in;
                        state_r     <= GF_HOLD;
                        busy_r      <= 1'b1;
                        mux_valid_r <= 1'b0;
`ifdef GFMUX_BLANK_EN
                        mux_out_r   <= {WIDTH{1'b0}};
`endif
                    end else begin
                        state_r <= GF_IDLE;
                    end
                end
                GF_HOLD: begin
`ifdef GFMUX_BLANK_EN
                    mux_out_r <= {WIDTH{1'b0}};
`else
                    mux_out_r <= mux_out_r;
`endif
                    if (cnt_zero_s) begin
                        state_r <= GF_SWITCH;
                    end else begin
                        state_r <= GF_HOLD;
                    end
                end
                GF_SWITCH: begin
                    cur_sel_r   <= pending_r;
                    mux_out_r   <= pick(data_in, pending_r);
                    mux_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    sel_ack_r   <= 1'b1;
                    state_r     <= GF_IDLE;
                end
                default: begin
                    state_r     <= GF_IDLE;
                    busy_r      <= 1'b0;
                    mux_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sel_ack   = sel_ack_r;
    assign sel_err   = sel_err_r;
    assign busy      = busy_r;
    assign cur_sel   = cur_sel_r;
    assign mux_out   = mux_out_r;
    assign mux_valid = mux_valid_r;

endmodule

// File: tb/tb_glitch_free_mux_reg.sv
// Directed self-checking bench for glitch_free_mux_reg (4-channel and 3-channel instances).
module tb_glitch_free_mux_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = {8'hC3, 8'h3C, 8'h5A, 8'hA5};
    logic [1:0]  sel_in = 2'd0;
    logic        sel_req = 1'b0;
    logic        sel_ack, sel_err, busy, mux_valid;
    logic [1:0]  cur_sel;
    logic [7:0]  mux_out;

    logic [23:0] data3 = {8'h33, 8'h22, 8'h11};
    logic [1:0]  sel_in3 = 2'd0;
    logic        sel_req3 = 1'b0;
    logic        sel_ack3, sel_err3, busy3, mux_valid3;
    logic [1:0]  cur_sel3;
    logic [7:0]  mux_out3;

    int tests = 0;
    int fails = 0;

`ifdef GFMUX_BLANK_EN
    localparam logic [7:0] HOLD_A5 = 8'h00;
    localparam logic [7:0] HOLD_11 = 8'h00;
`else
    localparam logic [7:0] HOLD_A5 = 8'hA5;
    localparam logic [7:0] HOLD_11 = 8'h11;
`endif

    glitch_free_mux_reg #(.WIDTH(8), .NCH(4), .HOLD_CYC(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sel_in(sel_in), .sel_req(sel_req),
        .sel_ack(sel_ack), .sel_err(sel_err), .busy(busy), .cur_sel(cur_sel),
        .mux_out(mux_out), .mux_valid(mux_valid)
    );

    glitch_free_mux_reg #(.WIDTH(8), .NCH(3), .HOLD_CYC(1)) dut3 (
        .clk(clk), .rst(rst), .data_in(data3), .sel_in(sel_in3), .sel_req(sel_req3),
        .sel_ack(sel_ack3), .sel_err(sel_err3), .busy(busy3), .cur_sel(cur_sel3),
        .mux_out(mux_out3), .mux_valid(mux_valid3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++; if (mux_out !== 8'hA5) begin fails++; $display("FAIL reset_first_mux: got %h expected %h", mux_out, 8'hA5); end
        tests++; if (mux_valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid: got %b expected 1", mux_valid); end
        tick();
        #1 rst = 1'b1;
        #1;
        tests++; if ({mux_out, mux_valid, busy, sel_ack, sel_err, cur_sel} !== 14'd0) begin
            fails++; $display("FAIL reset_async_clear: got mux=%h v=%b b=%b a=%b e=%b s=%0d expected all 0",
                              mux_out, mux_valid, busy, sel_ack, sel_err, cur_sel); end
        rst = 1'b0;
        tick();
        tests++; if (mux_out !== 8'hA5 || mux_valid !== 1'b1) begin fails++; $display("FAIL reset_release: got mux=%h v=%b expected A5/1", mux_out, mux_valid); end
        tests++; if (mux_out3 !== 8'h11) begin fails++; $display("FAIL reset_release3: got %h expected 11", mux_out3); end
    endtask

    task automatic test_switch();
        sel_in = 2'd2; sel_req = 1'b1;
        tick();
        sel_req = 1'b0;
        tests++; if (busy !== 1'b1 || mux_valid !== 1'b0) begin fails++; $display("FAIL switch_t1_busy: got b=%b v=%b expected 1/0", busy, mux_valid); end
        for (int c = 1; c <= 3; c++) begin
            tests++; if (mux_out !== HOLD_A5 || sel_ack !== 1'b0) begin fails++; $display("FAIL switch_hold_t%0d: got mux=%h ack=%b expected %h/0", c, mux_out, sel_ack, HOLD_A5); end
            tick();
        end
        tests++; if (sel_ack !== 1'b1 || mux_out !== 8'h3C) begin fails++; $display("FAIL switch_t4: got ack=%b mux=%h expected 1/3C", sel_ack, mux_out); end
        tests++; if (cur_sel !== 2'd2 || busy !== 1'b0 || mux_valid !== 1'b1) begin fails++; $display("FAIL switch_t4_state: got s=%0d b=%b v=%b expected 2/0/1", cur_sel, busy, mux_valid); end
        tick();
        tests++; if (sel_ack !== 1'b0) begin fails++; $display("FAIL switch_ack_pulse: got %b expected 0", sel_ack); end
    endtask

    task automatic test_same_and_invalid();
        sel_in = 2'd2; sel_req = 1'b1;
        tick();
        sel_req = 1'b0;
        tests++; if (sel_ack !== 1'b1 || busy !== 1'b0 || sel_err !== 1'b0) begin fails++; $display("FAIL same_ack: got a=%b b=%b e=%b expected 1/0/0", sel_ack, busy, sel_err); end
        tests++; if (mux_out !== 8'h3C || mux_valid !== 1'b1) begin fails++; $display("FAIL same_nofreeze: got mux=%h v=%b expected 3C/1", mux_out, mux_valid); end
        sel_in3 = 2'd3; sel_req3 = 1'b1;
        tick();
        sel_req3 = 1'b0;
        tests++; if (sel_err3 !== 1'b1 || sel_ack3 !== 1'b0) begin fails++; $display("FAIL invalid_err: got e=%b a=%b expected 1/0", sel_err3, sel_ack3); end
        tests++; if (cur_sel3 !== 2'd0 || busy3 !== 1'b0) begin fails++; $display("FAIL invalid_state: got s=%0d b=%b expected 0/0", cur_sel3, busy3); end
        tick();
        tests++; if (sel_err3 !== 1'b0) begin fails++; $display("FAIL invalid_pulse: got %b expected 0", sel_err3); end
        sel_in3 = 2'd2; sel_req3 = 1'b1;
        tick();
        sel_req3 = 1'b0;
        tests++; if (busy3 !== 1'b1 || mux_out3 !== HOLD_11) begin fails++; $display("FAIL hold1_t1: got b=%b mux=%h expected 1/%h", busy3, mux_out3, HOLD_11); end
        tick();
        tests++; if (sel_ack3 !== 1'b0 || mux_out3 !== HOLD_11) begin fails++; $display("FAIL hold1_t2: got a=%b mux=%h expected 0/%h", sel_ack3, mux_out3, HOLD_11); end
        tick();
        tests++; if (sel_ack3 !== 1'b1 || mux_out3 !== 8'h33 || cur_sel3 !== 2'd2) begin fails++; $display("FAIL hold1_t3: got a=%b mux=%h s=%0d expected 1/33/2", sel_ack3, mux_out3, cur_sel3); end
    endtask

    task automatic test_reset_in_hold();
        int acks;
        acks = 0;
        sel_in = 2'd1; sel_req = 1'b1;
        tick();
        sel_req = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rsthold_busy: got %b expected 1", busy); end
        #1 rst = 1'b1;
        #1;
        tests++; if (cur_sel !== 2'd0 || busy !== 1'b0 || mux_out !== 8'h00) begin fails++; $display("FAIL rsthold_clear: got s=%0d b=%b mux=%h expected 0/0/00", cur_sel, busy, mux_out); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (sel_ack === 1'b1) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL rsthold_noack: got %0d acks expected 0", acks); end
        tests++; if (cur_sel !== 2'd0 || mux_out !== 8'hA5 || mux_valid !== 1'b1) begin fails++; $display("FAIL rsthold_track: got s=%0d mux=%h v=%b expected 0/A5/1", cur_sel, mux_out, mux_valid); end
    endtask

    task automatic test_back_to_back();
        sel_in = 2'd2; sel_req = 1'b1;
        tick();
        sel_in = 2'd1;
        tick();
        tests++; if (cur_sel !== 2'd0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_ignored: got s=%0d b=%b expected 0/1", cur_sel, busy); end
        tick();
        sel_in = 2'd2;
        tests++; if (sel_ack !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_switch_cyc: got a=%b b=%b expected 0/1", sel_ack, busy); end
        tick();
        tests++; if (sel_ack !== 1'b1 || cur_sel !== 2'd2 || mux_out !== 8'h3C) begin fails++; $display("FAIL b2b_first_ack: got a=%b s=%0d mux=%h expected 1/2/3C", sel_ack, cur_sel, mux_out); end
        tick();
        tests++; if (sel_ack !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_second_ack: got a=%b b=%b expected 1/0", sel_ack, busy); end
        sel_req = 1'b0;
        tick();
        tests++; if (sel_ack !== 1'b0 || busy !== 1'b0 || mux_out !== 8'h3C) begin fails++; $display("FAIL b2b_idle: got a=%b b=%b mux=%h expected 0/0/3C", sel_ack, busy, mux_out); end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_and_invalid();
        test_reset_in_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
